// File: rtl/ad_bus_target_if.sv
// Multiplexed address/data bus between an initiator (master) and the
// ad_bus_target register block (slave).
interface ad_bus_target_if;
  logic        frame;
  logic        read;
  logic [31:0] ad_in;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        ready;

  modport master (
    output frame, read, ad_in,
    input  ad_out, ad_oe, ready
  );

  modport slave (
    input  frame, read, ad_in,
    output ad_out, ad_oe, ready
  );
endinterface

// File: rtl/ad_bus_target.sv
// Eight 16-bit registers decoded on a multiplexed address/data bus, with
// turnaround before read data and wrapping bursts.
// Optional parity checking/generation: define AD_BUS_TARGET_PARITY_EN.
module ad_bus_target #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              reset,
  ad_bus_target_if.slave    bus,
  output logic [15:0]       reg0
`ifdef AD_BUS_TARGET_PARITY_EN
  ,
  input  logic              par_in,
  output logic              par_out,
  output logic              perr
`endif
);

  typedef enum logic [2:0] {IDLE, TURN, RDATA, WDATA, IGNORE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic        cmd, cmd_nxt;
  logic        hit;
  logic        beat_ok;
  logic        wr_en;
  logic [15:0] regs [8];
  logic        unused_bits;

  assign hit         = (bus.ad_in[31:5] == BASE_ADDR[31:5]);
  assign unused_bits = ^bus.ad_in[1:0];
  assign reg0        = regs[0];

`ifdef AD_BUS_TARGET_PARITY_EN
  // Even parity across ad_in and par_in; a bad beat is dropped but still consumes its slot.
  assign beat_ok = ~(^bus.ad_in ^ par_in);
  assign par_out = (state == RDATA) ? ^bus.ad_out : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perr <= 1'b0;
    else       perr <= (state == WDATA) && !beat_ok;
  end
`else
  assign beat_ok = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 3'd0;
      cmd   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cmd   <= cmd_nxt;
    end
  end

  // NOTE: this register file has an asynchronous clear, so it must be built
  // from flops; a RAM macro could not honour the reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    end else if (wr_en) begin
      regs[idx] <= bus.ad_in[15:0];
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held (no latches).
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cmd_nxt    = cmd;
    wr_en      = 1'b0;
    bus.ad_oe  = 1'b0;
    bus.ready  = 1'b0;
    bus.ad_out = 32'h0000_0000;
    case (state)
      IDLE: begin
        if (bus.frame) begin
          idx_nxt = bus.ad_in[4:2];
          cmd_nxt = bus.read;
          if (!hit)          state_nxt = IGNORE;
          else if (bus.read) state_nxt = TURN;
          else               state_nxt = WDATA;
        end
      end
      TURN: begin
        state_nxt = bus.frame ? RDATA : IDLE;
      end
      RDATA: begin
        bus.ad_oe  = cmd;
        bus.ready  = 1'b1;
        bus.ad_out = {16'h0000, regs[idx]};
        idx_nxt    = idx + 3'd1;
        if (!bus.frame) state_nxt = IDLE;
      end
      WDATA: begin
        bus.ready = 1'b1;
        wr_en     = beat_ok;
        idx_nxt   = idx + 3'd1;
        if (!bus.frame) state_nxt = IDLE;
      end
      IGNORE: begin
        if (!bus.frame) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
